tx_frame_scheduler: RTL and testbench

Round-robin/fixed-priority scheduler that shares one serial frame transmitter between four requesters. It sits between the lab's data sources (switch-selected pattern generators, the receive-loopback path) and the single serial TX datapath driving the output pins. It sequences each frame (grant, start, wait busy, wait done, inter-frame gap), counts completed frames and flags protocol errors for LED/7-segment display.

---
 rtl/tx_frame_scheduler.sv | 168 ++++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: shares one serial frame transmitter between four requesters,
// sequencing grant/start/busy/done/gap per frame and flagging handshake errors.
module tx_frame_scheduler #(
    parameter int unsigned DW  = 8,
    parameter int unsigned GAP = 16,
    parameter int unsigned TMO = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] req_data,
    output logic [3:0]      gnt,
    output logic            tx_start,
    output logic [DW-1:0]   tx_data,
    input  logic            tx_busy,
    input  logic            tx_done,
    output logic [1:0]      cur_ch,
    output logic [15:0]     frame_cnt,
    output logic [1:0]      err,
    input  logic            err_clr
);
    localparam int unsigned NCH = 4;
    localparam int unsigned TW  = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int unsigned GW  = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
    logic [3:0]      gnt_nxt;
    logic            tx_start_nxt;
    logic [DW-1:0]   tx_data_nxt;
    logic [1:0]      cur_ch_nxt;
    logic [15:0]     frame_cnt_nxt;
    logic [1:0]      err_nxt;
    logic [1:0]      err_set;
    logic [1:0]      win;
    logic            grant;
    logic            tmo_hit;
    logic            gap_last;

    assign grant    = en && (req != 4'b0000);
    assign tmo_hit  = (tmo_cnt == TW'(TMO - 1));
    assign gap_last = (GAP == 0) ? 1'b1 : (gap_cnt == GW'(GAP - 1));

    // Winner: lowest set index (fixed) or first set index after cur_ch (round-robin)
    always_comb begin : pick
        logic [1:0] idx;
        idx = 2'd0;
        win = 2'd0;
        if (mode) begin
            for (int i = int'(NCH) - 1; i >= 0; i--) begin
                if (req[i]) win = 2'(i);
            end
        end else begin
            for (int k = int'(NCH); k >= 1; k--) begin
                idx = cur_ch + 2'(k);
                if (req[idx]) win = idx;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            gnt       <= 4'b0000;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            cur_ch    <= 2'd3;
            frame_cnt <= 16'h0000;
            err       <= 2'b00;
        end else begin
            state     <= state_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            gnt       <= gnt_nxt;
            tx_start  <= tx_start_nxt;
            tx_data   <= tx_data_nxt;
            cur_ch    <= cur_ch_nxt;
            frame_cnt <= frame_cnt_nxt;
            err       <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant) state_nxt = S_START;
            end
            S_START: begin
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy)      state_nxt = tx_done ? S_GAP : S_WAIT_DONE;
                else if (tmo_hit) state_nxt = S_GAP;
            end
            S_WAIT_DONE: begin
                if (tx_done) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and counters
    always_comb begin
        gnt_nxt       = 4'b0000;
        tx_start_nxt  = 1'b0;
        tx_data_nxt   = tx_data;
        cur_ch_nxt    = cur_ch;
        frame_cnt_nxt = frame_cnt;
        tmo_cnt_nxt   = '0;
        gap_cnt_nxt   = '0;
        err_set       = 2'b00;
        case (state)
            S_IDLE: begin
                err_set[1] = tx_done;
                if (grant) begin
                    gnt_nxt[win] = 1'b1;
                    tx_data_nxt  = req_data[win*DW +: DW];
                    cur_ch_nxt   = win;
                end
            end
            S_START: begin
                err_set[1]   = tx_done;
                tx_start_nxt = 1'b1;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    if (tx_done) frame_cnt_nxt = frame_cnt + 16'd1;
                end else if (tmo_hit) begin
                    err_set[0] = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) frame_cnt_nxt = frame_cnt + 16'd1;
            end
            S_GAP: begin
                err_set[1] = tx_done;
                if (!gap_last) gap_cnt_nxt = gap_cnt + GW'(1);
            end
            default: begin
                err_set = 2'b00;
            end
        endcase
        // A new error wins over a simultaneous clear
        err_nxt = (err & ~{2{err_clr}}) | err_set;
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler: a transmitter model answers each
// start, and a reference arbiter/counter model predicts every grant and count.
module tb_tx_frame_scheduler;
    localparam int unsigned DW    = 8;
    localparam int unsigned GAP_C = 16;
    localparam int unsigned TMO_C = 255;
    localparam int          WAIT_LIM = 400;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            mode;
    logic [3:0]      req;
    logic [4*DW-1:0] req_data;
    logic [3:0]      gnt;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_busy;
    logic            tx_done;
    logic [1:0]      cur_ch;
    logic [15:0]     frame_cnt;
    logic [1:0]      err;
    logic            err_clr;

    int          vec  = 0;
    int          errs = 0;
    int          cyc  = 0;
    logic [1:0]  m_last;
    logic [15:0] m_cnt;

    tx_frame_scheduler #(.DW(DW), .GAP(GAP_C), .TMO(TMO_C)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req),
        .req_data(req_data), .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .cur_ch(cur_ch),
        .frame_cnt(frame_cnt), .err(err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbiter: scan upward from a start index, wrapping modulo 4
    function automatic logic [1:0] model_pick(input logic [3:0] r, input logic m,
                                              input logic [1:0] last);
        int start;
        start = m ? 0 : (int'(last) + 1) % 4;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (start + k) % 4;
            if (r[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    // One complete frame: await grant, answer start with busy (1-cycle latency) then done
    task automatic run_frame(input int blen, input bit both, input bit hold,
                             input bit drop_en, output int gcyc);
        int n;
        logic [1:0]    ch;
        logic [DW-1:0] exp_data;
        n = 0;
        gcyc = -1;
        while (gnt === 4'b0000 && n < WAIT_LIM) begin
            tick();
            n++;
        end
        vec++;
        if (gnt === 4'b0000) begin
            errs++;
            $display("FAIL grant_wait: no gnt after %0d cycles, req=%b want a grant", n, req);
            return;
        end
        gcyc = cyc;
        ch = model_pick(req, mode, m_last);
        exp_data = req_data[ch*DW +: DW];
        vec++;
        if (gnt !== (4'b0001 << ch)) begin
            errs++;
            $display("FAIL gnt: got %b want %b (req=%b mode=%b)", gnt, 4'b0001 << ch, req, mode);
        end
        vec++;
        if (tx_data !== exp_data) begin
            errs++;
            $display("FAIL tx_data: got %h want %h", tx_data, exp_data);
        end
        vec++;
        if (cur_ch !== ch) begin
            errs++;
            $display("FAIL cur_ch: got %0d want %0d", cur_ch, ch);
        end
        vec++;
        if (tx_start !== 1'b0) begin
            errs++;
            $display("FAIL start_early: tx_start got %b want 0 in grant cycle", tx_start);
        end
        m_last = ch;
        if (!hold) req[ch] = 1'b0;
        if (drop_en) en = 1'b0;
        tick();
        vec++;
        if (gnt !== 4'b0000 || tx_start !== 1'b1) begin
            errs++;
            $display("FAIL start_pulse: gnt=%b tx_start=%b want 0000/1", gnt, tx_start);
        end
        tick();
        vec++;
        if (tx_start !== 1'b0) begin
            errs++;
            $display("FAIL start_width: tx_start got %b want 0", tx_start);
        end
        tx_busy = 1'b1;
        tx_done = both;
        if (both) begin
            tick();
            tx_busy = 1'b0;
            tx_done = 1'b0;
        end else begin
            repeat (blen) tick();
            vec++;
            if (frame_cnt !== m_cnt) begin
                errs++;
                $display("FAIL cnt_early: frame_cnt got %h want %h", frame_cnt, m_cnt);
            end
            tx_busy = 1'b0;
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        m_cnt = m_cnt + 16'd1;
        vec++;
        if (frame_cnt !== m_cnt) begin
            errs++;
            $display("FAIL frame_cnt: got %h want %h", frame_cnt, m_cnt);
        end
        vec++;
        if (tx_data !== exp_data) begin
            errs++;
            $display("FAIL tx_data_hold: got %h want %h", tx_data, exp_data);
        end
    endtask

    task automatic idle_wait();
        repeat (GAP_C + 4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        vec++;
        if (gnt !== 4'b0000 || tx_start !== 1'b0 || tx_data !== '0 || cur_ch !== 2'd3 ||
            frame_cnt !== 16'h0000 || err !== 2'b00) begin
            errs++;
            $display("FAIL reset_state: gnt=%b start=%b data=%h ch=%0d cnt=%h err=%b want 0000/0/00/3/0000/00",
                     gnt, tx_start, tx_data, cur_ch, frame_cnt, err);
        end
        rst_n = 1'b1;
        m_last = 2'd3;
        m_cnt = 16'h0000;
        tick();
    endtask

    task automatic test_rr_fairness();
        int g, g_prev, b, b_prev;
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        mode = 1'b0;
        req = 4'b1111;
        req_data = 32'($urandom);
        g_prev = -1;
        b_prev = 0;
        for (int f = 0; f < 5; f++) begin
            b = int'($urandom_range(1, 6));
            run_frame(b, 1'b0, 1'b1, 1'b0, g);
            vec++;
            if (m_last !== order[f] || cur_ch !== order[f]) begin
                errs++;
                $display("FAIL rr_order: frame %0d cur_ch got %0d want %0d", f, cur_ch, order[f]);
            end
            if (g_prev >= 0) begin
                vec++;
                if (g - g_prev != 4 + b_prev + int'(GAP_C)) begin
                    errs++;
                    $display("FAIL rr_period: grant spacing got %0d want %0d", g - g_prev,
                             4 + b_prev + int'(GAP_C));
                end
            end
            g_prev = g;
            b_prev = b;
        end
        req = 4'b0000;
        idle_wait();
    endtask

    task automatic test_single();
        int g;
        mode = 1'b0;
        req_data = 32'($urandom);
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        run_frame(10, 1'b0, 1'b0, 1'b0, g);
        vec++;
        if (tx_data !== 8'hA5 || err !== 2'b00) begin
            errs++;
            $display("FAIL single: tx_data=%h err=%b want a5/00", tx_data, err);
        end
        idle_wait();
    endtask

    task automatic test_fixed_priority();
        int g;
        mode = 1'b1;
        req = 4'b1010;
        req_data = 32'($urandom);
        for (int f = 0; f < 3; f++) begin
            run_frame(int'($urandom_range(1, 5)), 1'b0, 1'b1, 1'b0, g);
            vec++;
            if (cur_ch !== 2'd1) begin
                errs++;
                $display("FAIL fixed_prio: cur_ch got %0d want 1", cur_ch);
            end
        end
        mode = 1'b0;
        run_frame(3, 1'b0, 1'b0, 1'b0, g);
        vec++;
        if (cur_ch !== 2'd3) begin
            errs++;
            $display("FAIL mode_switch: cur_ch got %0d want 3", cur_ch);
        end
        req = 4'b0000;
        idle_wait();
    endtask

    task automatic test_random();
        int g;
        for (int f = 0; f < 24; f++) begin
            req = 4'($urandom_range(1, 15));
            mode = 1'($urandom_range(0, 1));
            req_data = 32'($urandom);
            run_frame(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0), 1'b0, 1'b0, g);
            req = 4'b0000;
        end
        vec++;
        if (err !== 2'b00) begin
            errs++;
            $display("FAIL random_err: err got %b want 00", err);
        end
        idle_wait();
    endtask

    task automatic test_enable();
        int g, seen;
        en = 1'b0;
        req = 4'b0001;
        req_data = 32'($urandom);
        seen = 0;
        repeat (GAP_C + 10) begin
            tick();
            if (gnt !== 4'b0000) seen++;
        end
        vec++;
        if (seen != 0) begin
            errs++;
            $display("FAIL en_low: %0d grants seen want 0", seen);
        end
        en = 1'b1;
        run_frame(4, 1'b0, 1'b0, 1'b1, g);
        req = 4'b1111;
        seen = 0;
        repeat (GAP_C + 10) begin
            tick();
            if (gnt !== 4'b0000) seen++;
        end
        vec++;
        if (seen != 0) begin
            errs++;
            $display("FAIL en_drop: %0d grants seen want 0", seen);
        end
        req = 4'b0000;
        en = 1'b1;
        tick();
    endtask

    task automatic test_busy_timeout();
        int n, g, g2;
        logic [1:0] ch;
        mode = 1'b0;
        req = 4'b0001;
        req_data = 32'($urandom);
        n = 0;
        while (gnt === 4'b0000 && n < WAIT_LIM) begin
            tick();
            n++;
        end
        g = cyc;
        ch = model_pick(req, mode, m_last);
        vec++;
        if (gnt !== (4'b0001 << ch)) begin
            errs++;
            $display("FAIL tmo_gnt: got %b want %b", gnt, 4'b0001 << ch);
        end
        m_last = ch;
        req = 4'b0000;
        while (cyc < g + int'(TMO_C)) tick();
        vec++;
        if (err !== 2'b00) begin
            errs++;
            $display("FAIL tmo_early: err got %b want 00 at START+%0d", err, TMO_C - 1);
        end
        tick();
        vec++;
        if (err !== 2'b01 || frame_cnt !== m_cnt) begin
            errs++;
            $display("FAIL tmo_set: err=%b cnt=%h want 01/%h", err, frame_cnt, m_cnt);
        end
        req = 4'b0010;
        run_frame(2, 1'b0, 1'b0, 1'b0, g2);
        vec++;
        if (g2 - g != int'(TMO_C) + int'(GAP_C) + 2) begin
            errs++;
            $display("FAIL tmo_return: regrant after %0d cycles want %0d", g2 - g,
                     int'(TMO_C) + int'(GAP_C) + 2);
        end
        vec++;
        if (err !== 2'b01) begin
            errs++;
            $display("FAIL tmo_sticky: err got %b want 01", err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vec++;
        if (err !== 2'b00) begin
            errs++;
            $display("FAIL err_clr: err got %b want 00", err);
        end
        idle_wait();
    endtask

    task automatic test_spurious_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        vec++;
        if (err !== 2'b10) begin
            errs++;
            $display("FAIL spurious: err got %b want 10", err);
        end
        tx_done = 1'b1;
        err_clr = 1'b1;
        tick();
        tx_done = 1'b0;
        vec++;
        if (err !== 2'b10) begin
            errs++;
            $display("FAIL clr_vs_set: err got %b want 10", err);
        end
        tick();
        err_clr = 1'b0;
        vec++;
        if (err !== 2'b00) begin
            errs++;
            $display("FAIL clr_after: err got %b want 00", err);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n, g;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        mode = 1'b0;
        req = 4'b0001;
        req_data = 32'h5A5A_5AC3;
        n = 0;
        while (gnt === 4'b0000 && n < WAIT_LIM) begin
            tick();
            n++;
        end
        vec++;
        if (gnt === 4'b0000) begin
            errs++;
            $display("FAIL rst_grant: no gnt after %0d cycles want a grant", n);
        end
        req = 4'b0000;
        tick();
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if (gnt !== 4'b0000 || tx_start !== 1'b0 || tx_data !== '0 || cur_ch !== 2'd3 ||
            frame_cnt !== 16'h0000 || err !== 2'b00) begin
            errs++;
            $display("FAIL reset_mid: gnt=%b start=%b data=%h ch=%0d cnt=%h err=%b want 0000/0/00/3/0000/00",
                     gnt, tx_start, tx_data, cur_ch, frame_cnt, err);
        end
        tick();
        tx_busy = 1'b0;
        rst_n = 1'b1;
        m_last = 2'd3;
        m_cnt = 16'h0000;
        tick();
        req = 4'b0100;
        run_frame(2, 1'b0, 1'b0, 1'b0, g);
        vec++;
        if (cur_ch !== 2'd2) begin
            errs++;
            $display("FAIL post_reset: cur_ch got %0d want 2", cur_ch);
        end
        idle_wait();
    endtask

    task automatic test_cnt_wrap();
        int g;
        force dut.frame_cnt = 16'hFFFF;
        tick();
        tick();
        release dut.frame_cnt;
        m_cnt = 16'hFFFF;
        req = 4'b0100;
        req_data = 32'($urandom);
        run_frame(3, 1'b0, 1'b0, 1'b0, g);
        vec++;
        if (frame_cnt !== 16'h0000) begin
            errs++;
            $display("FAIL cnt_wrap: frame_cnt got %h want 0000", frame_cnt);
        end
        idle_wait();
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        mode     = 1'b0;
        req      = 4'b0000;
        req_data = '0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        err_clr  = 1'b0;
        m_last   = 2'd3;
        m_cnt    = 16'h0000;
        test_reset();
        test_rr_fairness();
        test_single();
        test_fixed_priority();
        test_random();
        test_enable();
        test_busy_timeout();
        test_spurious_done();
        test_reset_mid_frame();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
